// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle controller and its datapath: opcode and
// memory handshake toward the controller, datapath control strobes back.
interface multicycle_control_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       ALUSrcA;
  logic       RegWrite;
  logic       RegDst;
  logic [1:0] PCSource;
  logic [1:0] ALUSrcB;
  logic       ALUOp1;
  logic       ALUOp0;
  logic       illegal_op;
  logic [3:0] state;

  // Datapath side: supplies opcode and memory handshake, consumes controls.
  modport master (
    output op, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp1, ALUOp0,
           illegal_op, state
  );

  // Controller side.
  modport slave (
    input  op, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp1, ALUOp0,
           illegal_op, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style main controller: a 12-state FSM sequencing fetch,
// decode, memory, execute and writeback, with controls decoded from the state.
module multicycle_control (
  input logic               clk,
  input logic               reset,
  multicycle_control_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEMADDR   = 4'd2,
    MEMREAD   = 4'd3,
    MEMWB     = 4'd4,
    MEMWRITE  = 4'd5,
    EXEC      = 4'd6,
    RCOMPLETE = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    EXECI     = 4'd10,
    ICOMPLETE = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t     r_state;

  logic       w_pcwrite;
  logic       w_pcwritecond;
  logic       w_iord;
  logic       w_memread;
  logic       w_memwrite;
  logic       w_memtoreg;
  logic       w_irwrite;
  logic       w_alusrca;
  logic       w_regwrite;
  logic       w_regdst;
  logic [1:0] w_pcsource;
  logic [1:0] w_alusrcb;
  logic [1:0] w_aluop;
  logic       w_illegal;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_supported = 1'b1;
      default:                                        op_supported = 1'b0;
    endcase
  endfunction

  // State register; unused encodings fall back to FETCH through the default.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      case (r_state)
        FETCH:     if (bus.mem_ready) r_state <= DECODE;
        DECODE: begin
          case (bus.op)
            OP_RTYPE:     r_state <= EXEC;
            OP_LW, OP_SW: r_state <= MEMADDR;
            OP_BEQ:       r_state <= BRANCH;
            OP_J:         r_state <= JUMP;
            OP_ADDI:      r_state <= EXECI;
            default:      r_state <= FETCH;
          endcase
        end
        MEMADDR:   r_state <= (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD:   if (bus.mem_ready) r_state <= MEMWB;
        MEMWRITE:  if (bus.mem_ready) r_state <= FETCH;
        EXEC:      r_state <= RCOMPLETE;
        EXECI:     r_state <= ICOMPLETE;
        default:   r_state <= FETCH;
      endcase
    end
  end

  // Controls are a pure decode of r_state so that IRWrite/PCWrite can follow
  // mem_ready within the same FETCH cycle.
  always_comb begin
    w_pcwrite     = 1'b0;
    w_pcwritecond = 1'b0;
    w_iord        = 1'b0;
    w_memread     = 1'b0;
    w_memwrite    = 1'b0;
    w_memtoreg    = 1'b0;
    w_irwrite     = 1'b0;
    w_alusrca     = 1'b0;
    w_regwrite    = 1'b0;
    w_regdst      = 1'b0;
    w_pcsource    = 2'b00;
    w_alusrcb     = 2'b00;
    w_aluop       = 2'b00;
    case (r_state)
      FETCH: begin
        w_memread = 1'b1;
        w_alusrcb = 2'b01;
        w_irwrite = bus.mem_ready;
        w_pcwrite = bus.mem_ready;
      end
      DECODE:    w_alusrcb = 2'b11;
      MEMADDR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      MEMREAD: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
      end
      MEMWRITE: begin
        w_memwrite = 1'b1;
        w_iord     = 1'b1;
      end
      MEMWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
      end
      EXEC: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
      end
      RCOMPLETE: begin
        w_regwrite = 1'b1;
        w_regdst   = 1'b1;
      end
      EXECI: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      ICOMPLETE: w_regwrite = 1'b1;
      BRANCH: begin
        w_alusrca     = 1'b1;
        w_aluop       = 2'b01;
        w_pcwritecond = 1'b1;
        w_pcsource    = 2'b01;
      end
      JUMP: begin
        w_pcwrite  = 1'b1;
        w_pcsource = 2'b10;
      end
      default: ;
    endcase
  end

  assign w_illegal = (r_state == DECODE) && !op_supported(bus.op);

  // Reset masks every state-changing strobe, and MemRead so an interrupted
  // access does not keep the memory busy.
  assign bus.PCWrite     = w_pcwrite     & ~reset;
  assign bus.PCWriteCond = w_pcwritecond & ~reset;
  assign bus.IRWrite     = w_irwrite     & ~reset;
  assign bus.MemWrite    = w_memwrite    & ~reset;
  assign bus.RegWrite    = w_regwrite    & ~reset;
  assign bus.illegal_op  = w_illegal     & ~reset;
  assign bus.MemRead     = w_memread     & ~reset;
  assign bus.IorD        = w_iord;
  assign bus.MemtoReg    = w_memtoreg;
  assign bus.ALUSrcA     = w_alusrca;
  assign bus.RegDst      = w_regdst;
  assign bus.PCSource    = w_pcsource;
  assign bus.ALUSrcB     = w_alusrcb;
  assign bus.ALUOp1      = w_aluop[1];
  assign bus.ALUOp0      = w_aluop[0];
  assign bus.state       = r_state;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high; sampled on rising edge of clk.
REQ-004 op  input  6  instruction opcode field from the instruction register, valid from DECODE onward.
REQ-005 mem_ready  input  1  memory access completes this cycle.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls.
REQ-007 PCSource  output  2  PC mux select; ALUSrcB  output  2  ALU B mux select.
REQ-008 ALUOp1, ALUOp0  output  1 each  feed the downstream ALU control stage: 00 = add, 01 = subtract, 10 = decode funct.
REQ-009 illegal_op  output  1  one-cycle pulse on unsupported opcode.
REQ-010 state  output  4  current state encoding, for debug.

Function
REQ-011 States and encodings SHALL be:
- FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
- EXEC=6, RCOMPLETE=7, BRANCH=8, JUMP=9, EXECI=10, ICOMPLETE=11
- Encodings 12-15 are unused.
REQ-012 Transitions:
- FETCH->DECODE when mem_ready=1, else hold.
- DECODE by op: 000000->EXEC; 100011 or 101011->MEMADDR; 000100->BRANCH; 000010->JUMP; 001000->EXECI; any other->FETCH.
- MEMADDR->MEMREAD if op=100011, else MEMWRITE.
- MEMREAD->MEMWB when mem_ready=1, else hold.
- MEMWRITE->FETCH when mem_ready=1, else hold.
- EXEC->RCOMPLETE; EXECI->ICOMPLETE.
- MEMWB, RCOMPLETE, ICOMPLETE, BRANCH, JUMP->FETCH.
- Encodings 12-15->FETCH.
REQ-013 Outputs SHALL be decoded from the state register only, plus mem_ready where stated; every output not listed for a state is 0.
REQ-014 FETCH: MemRead=1, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready.
REQ-015 DECODE: ALUSrcB=11, ALUOp=00 (branch target precompute).
REQ-016 MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-017 MEMREAD: MemRead=1, IorD=1. MEMWRITE: MemWrite=1, IorD=1.
REQ-018 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
REQ-019 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. RCOMPLETE: RegWrite=1, RegDst=1, MemtoReg=0.
REQ-020 EXECI: ALUSrcA=1, ALUSrcB=10, ALUOp=00. ICOMPLETE: RegWrite=1, RegDst=0, MemtoReg=0.
REQ-021 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
REQ-022 JUMP: PCWrite=1, PCSource=10.
REQ-023 illegal_op SHALL be 1 exactly in the DECODE cycle with an unsupported op; it SHALL NOT be raised in states 12-15.
REQ-024 ALUOp=11 SHALL never be driven.
REQ-025 MemRead and MemWrite SHALL never both be 1.
REQ-026 mem_ready SHALL be ignored outside FETCH, MEMREAD and MEMWRITE.
REQ-027 Instruction latency with mem_ready=1 throughout:
- lw 5 cycles
- sw, R-type, addi 4 cycles
- beq, j 3 cycles

Reset
REQ-028 With reset=1 at a rising edge, state SHALL become FETCH regardless of current state or mem_ready, including mid-access.
REQ-029 While reset=1, PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite and illegal_op SHALL be forced to 0.
REQ-030 After the first cycle with reset=0, outputs SHALL equal the FETCH decode.

Verification
REQ-031 Reset 2 cycles, then op=100011, mem_ready=1 -> state sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-032 op=000000, mem_ready=1 -> states 0,1,6,7,0; ALUOp1,ALUOp0=1,0 in state 6; RegDst=1 and RegWrite=1 in state 7.
REQ-033 op=101011 with mem_ready=0 for 3 cycles in MEMWRITE -> MemWrite=1 held for 4 cycles, then FETCH; RegWrite never 1.
REQ-034 op=000100 -> state 8 with ALUOp=01, PCWriteCond=1, PCSource=01; op=000010 -> state 9 with PCWrite=1, PCSource=10.
REQ-035 op=111111 -> illegal_op=1 for exactly the DECODE cycle, next state FETCH, no write enable asserted.
REQ-036 reset asserted in MEMREAD with mem_ready=0 -> state=0 after that edge; MemRead=0 while reset=1 if state was not yet FETCH; FETCH outputs in the first cycle after reset deasserts.
